nios_cpu_out_pio: RTL and testbench

- Avalon-MM slave parallel output port for the Nios CPU subsystem; CPU writes drive a registered `out_port`.
- Complements the input PIO: the same 2-bit word-address slave style, with the write path added.
- Adds a hardware-timed pulse register so firmware can emit fixed-width strobes (resets, enables, LED blips) without software delay loops.
- Optional atomic bit-set/bit-clear registers.

---
 rtl/nios_cpu_out_pio.sv | 114 +++++++++++
 tb/tb_nios_cpu_out_pio.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nios_cpu_out_pio.sv
// Avalon-MM output PIO with a data register and a hardware-timed pulse register.
// Define OUT_PIO_BITSET_EN to add atomic OUTSET (addr 2) / OUTCLEAR (addr 3) registers.
module nios_cpu_out_pio #(
    parameter int WIDTH        = 8,
    parameter int RESET_VALUE  = 0,
    parameter int PULSE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_busy
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);
    localparam logic [WIDTH-1:0] RST_DATA   = WIDTH'(RESET_VALUE);
    localparam logic [CW-1:0]    PULSE_LOAD = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0]    COUNT_ONE  = CW'(1);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_PULSE    = 2'd1;
`ifdef OUT_PIO_BITSET_EN
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;
`endif

    logic [WIDTH-1:0] data_reg, data_next;
    logic [WIDTH-1:0] mask_reg, mask_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] value;
    logic [31:0]      read_next;
    logic             wr_en;
    logic             pulse_active_next;
    logic             unused_ok;

    assign wr_en     = chipselect & ~write_n;
    assign value     = writedata[WIDTH-1:0];
    assign unused_ok = &{1'b0, writedata[31:WIDTH]};

    always_comb begin
        data_next = data_reg;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_next = value;
`ifdef OUT_PIO_BITSET_EN
                ADDR_OUTSET:   data_next = data_reg | value;
                ADDR_OUTCLEAR: data_next = data_reg & ~value;
`endif
                default:       data_next = data_reg;
            endcase
        end
    end

    // A PULSE write loads or cancels (zero value); otherwise the counter runs down and
    // clears the mask on its final 1->0 step.
    always_comb begin
        mask_next  = mask_reg;
        count_next = count_reg;
        if (wr_en && address == ADDR_PULSE) begin
            mask_next  = value;
            count_next = (value != '0) ? PULSE_LOAD : '0;
        end else if (count_reg != '0) begin
            count_next = count_reg - COUNT_ONE;
            if (count_reg == COUNT_ONE) begin
                mask_next = '0;
            end
        end
    end

    assign pulse_active_next = (count_next != '0);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_out_bit
            assign out_next[gi] = data_next[gi] ^ (mask_next[gi] & pulse_active_next);
        end
    endgenerate

    assign pulse_busy = (count_reg != '0);

    always_comb begin
        read_next = '0;
        case (address)
            ADDR_DATA: read_next[WIDTH-1:0] = out_port;
            ADDR_PULSE: begin
                read_next[WIDTH-1:0] = mask_reg;
                read_next[31]        = pulse_busy;
            end
            default: read_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg  <= RST_DATA;
            mask_reg  <= '0;
            count_reg <= '0;
            out_port  <= RST_DATA;
            readdata  <= '0;
        end else begin
            data_reg  <= data_next;
            mask_reg  <= mask_next;
            count_reg <= count_next;
            out_port  <= out_next;
            readdata  <= read_next;
        end
    end

endmodule

// File: tb/tb_nios_cpu_out_pio.sv
// Directed plus randomized bench for nios_cpu_out_pio against a cycle-level behavioural model.
module tb_nios_cpu_out_pio;

    localparam int          PULSE = 16;
    localparam logic [7:0]  RSTV  = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        pulse_busy;

    int vectors = 0;
    int miscompares = 0;

    // model state: output level, pulse mask and cycles of pulse remaining
    logic [7:0]  m_data = RSTV;
    logic [7:0]  m_mask = 8'h00;
    int          m_rem  = 0;
    logic [7:0]  m_out  = RSTV;
    logic [31:0] m_rd   = 32'd0;

    nios_cpu_out_pio #(
        .WIDTH(8),
        .RESET_VALUE(32'hA5),
        .PULSE_CYCLES(PULSE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port),
        .pulse_busy(pulse_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = RSTV;
        m_mask = 8'h00;
        m_rem  = 0;
        m_out  = RSTV;
        m_rd   = 32'd0;
    endtask

    task automatic model_edge(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
        logic [7:0] v;
        logic       wr;
        v  = wd[7:0];
        wr = cs && !wn;
        if (a == 2'd0)      m_rd = {24'd0, m_out};
        else if (a == 2'd1) m_rd = {(m_rem > 0), 23'd0, m_mask};
        else                m_rd = 32'd0;
        if (wr && a == 2'd1) begin
            m_mask = v;
            m_rem  = (v != 8'h00) ? PULSE : 0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_mask = 8'h00;
        end
        if (wr && a == 2'd0) m_data = v;
`ifdef OUT_PIO_BITSET_EN
        if (wr && a == 2'd2) m_data = m_data | v;
        if (wr && a == 2'd3) m_data = m_data & ~v;
`endif
        m_out = m_data ^ ((m_rem > 0) ? m_mask : 8'h00);
    endtask

    // inputs change on the falling edge; outputs are checked on the next falling edge
    task automatic step(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        model_edge(cs, wn, a, wd);
        @(negedge clk);
        check("out_port", {24'd0, out_port}, {24'd0, m_out});
        check("pulse_busy", {31'd0, pulse_busy}, {31'd0, (m_rem > 0)});
        check("readdata", readdata, m_rd);
    endtask

    task automatic idle(input logic [1:0] a);
        step(1'b0, 1'b1, a, $urandom);
    endtask

    initial begin
        int busy_n;
        logic [7:0] exp_bits;

        repeat (2) @(negedge clk);
        check("reset_out", {24'd0, out_port}, 32'h000000A5);
        check("reset_rd", readdata, 32'd0);
        check("reset_busy", {31'd0, pulse_busy}, 32'd0);
        reset_n = 1'b1;

        idle(2'd0);
        check("rd_after_reset", readdata, 32'h000000A5);

        step(1'b1, 1'b0, 2'd0, 32'hFFFF_FF3C);
        check("data_write", {24'd0, out_port}, 32'h0000003C);
        idle(2'd0);
        check("data_readback", readdata, 32'h0000003C);
        step(1'b0, 1'b0, 2'd0, 32'h0000_0055);
        check("cs_low_write", {24'd0, out_port}, 32'h0000003C);

        step(1'b1, 1'b0, 2'd0, 32'h0);
        step(1'b1, 1'b0, 2'd1, 32'h0000_0081);
        check("pulse_on", {24'd0, out_port}, 32'h00000081);
        busy_n = pulse_busy ? 1 : 0;
        idle(2'd1);
        check("pulse_rd", readdata, 32'h80000081);
        busy_n += pulse_busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            idle(2'd1);
            busy_n += pulse_busy ? 1 : 0;
        end
        check("busy_len", busy_n, PULSE);
        check("pulse_done", {24'd0, out_port}, 32'h0);
        check("pulse_rd_after", readdata, 32'h0);

        step(1'b1, 1'b0, 2'd1, 32'h01);
        repeat (5) idle(2'd1);
        step(1'b1, 1'b0, 2'd1, 32'h02);
        check("retrigger", {24'd0, out_port}, 32'h02);
        repeat (20) idle(2'd0);

        step(1'b1, 1'b0, 2'd1, 32'h04);
        repeat (3) idle(2'd1);
        step(1'b1, 1'b0, 2'd1, 32'h00);
        check("cancel_out", {24'd0, out_port}, 32'h0);
        check("cancel_busy", {31'd0, pulse_busy}, 32'd0);

        step(1'b1, 1'b0, 2'd1, 32'h08);
        repeat (9) idle(2'd1);
        reset_n = 1'b0;
        #1;
        check("midreset_out", {24'd0, out_port}, {24'd0, RSTV});
        check("midreset_busy", {31'd0, pulse_busy}, 32'd0);
        check("midreset_rd", readdata, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) idle(2'd1);

        step(1'b1, 1'b0, 2'd0, 32'h0F);
        step(1'b1, 1'b0, 2'd2, 32'h30);
        step(1'b1, 1'b0, 2'd3, 32'h03);
`ifdef OUT_PIO_BITSET_EN
        exp_bits = 8'h3C;
`else
        exp_bits = 8'h0F;
`endif
        check("bitset_out", {24'd0, out_port}, {24'd0, exp_bits});
        idle(2'd2);
        check("rd_addr2", readdata, 32'd0);
        idle(2'd3);
        check("rd_addr3", readdata, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] wd;
            wd = $urandom;
            if ($urandom_range(0, 5) == 0) wd = 32'd0;
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
